bram_word_loader: RTL and testbench

Write-side companion to the 4096×16 sample block memory (`blk_mem_gen_0`), which the playback path reads sequentially. It accepts a byte stream with a valid/ready handshake and packs byte pairs big-endian into 16-bit words. Each word is written to port A of the memory at consecutive addresses starting from 0. It reports progress and signals completion when flushed or when the memory is full.

---
 rtl/bram_word_loader_if.sv | 29 ++
 rtl/bram_word_loader.sv | 156 +++++++++++++++
 tb/tb_bram_word_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_word_loader_if.sv
// Byte-stream and memory-write bundle for bram_word_loader.
// The master drives the stream and control inputs. The slave (the loader)
// drives the handshake ready, the memory port A write bus and the status flags.
interface bram_word_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [15:0]       bram_din;
  logic [ADDR_W:0]   words_written;
  logic              busy;
  logic              done;
  logic              full;

  modport master (
    output start, in_byte, in_valid, flush,
    input  in_ready, bram_we, bram_addr, bram_din, words_written, busy, done, full
  );

  modport slave (
    input  start, in_byte, in_valid, flush,
    output in_ready, bram_we, bram_addr, bram_din, words_written, busy, done, full
  );
endinterface

// File: rtl/bram_word_loader.sv
// Packs a byte stream big-endian into 16-bit words and writes them to
// consecutive addresses of the sample memory, starting at 0. A load ends on
// flush (a partial word is padded with 0x00) or when the memory is full.
module bram_word_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input logic                CLK,
  input logic                RST,
  bram_word_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_r;
  state_t              state_next_s;

  logic                in_ready_s;
  logic                clear_s;        // start of a new load
  logic                load_hi_s;      // take in_byte as the high byte
  logic                load_word_s;    // LO exit: present the word on the write bus
  logic                set_flushing_s; // word was closed by flush
  logic                finish_wr_s;    // WR cycle completes a write

  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [15:0]         bram_din_r;
  logic [7:0]          hi_r;
  logic [ADDR_W:0]     words_written_r;
  logic                full_r;
  logic                flushing_r;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s   = state_r;
    in_ready_s     = 1'b0;
    clear_s        = 1'b0;
    load_hi_s      = 1'b0;
    load_word_s    = 1'b0;
    set_flushing_s = 1'b0;
    finish_wr_s    = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          clear_s      = 1'b1;
          state_next_s = S_HI;
        end else begin
          state_next_s = state_r;
        end
      end
      S_HI: begin
        in_ready_s = !bus.flush;
        if (bus.flush) begin
          state_next_s = S_DONE;
        end else if (bus.in_valid) begin
          load_hi_s    = 1'b1;
          state_next_s = S_LO;
        end else begin
          state_next_s = S_HI;
        end
      end
      S_LO: begin
        // flush wins over a simultaneous byte; the byte is not taken
        in_ready_s = !bus.flush;
        if (bus.flush) begin
          load_word_s    = 1'b1;
          set_flushing_s = 1'b1;
          state_next_s   = S_WR;
        end else if (bus.in_valid) begin
          load_word_s  = 1'b1;
          state_next_s = S_WR;
        end else begin
          state_next_s = S_LO;
        end
      end
      S_WR: begin
        finish_wr_s = 1'b1;
        if ((addr_r == LAST_ADDR) || flushing_r) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_HI;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Address counter, byte latch, write-bus registers and status counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_r          <= '0;
      bram_addr_r     <= '0;
      bram_din_r      <= 16'h0000;
      hi_r            <= 8'h00;
      words_written_r <= '0;
      full_r          <= 1'b0;
      flushing_r      <= 1'b0;
    end else begin
      if (clear_s) begin
        addr_r          <= '0;
        words_written_r <= '0;
        full_r          <= 1'b0;
        flushing_r      <= 1'b0;
      end
      if (load_hi_s) begin
        hi_r <= bus.in_byte;
      end
      if (load_word_s) begin
        // write bus only changes here, so it holds its last values outside WR
        bram_addr_r <= addr_r;
        bram_din_r  <= {hi_r, (set_flushing_s ? 8'h00 : bus.in_byte)};
      end
      if (set_flushing_s) begin
        flushing_r <= 1'b1;
      end
      if (finish_wr_s) begin
        words_written_r <= words_written_r + (ADDR_W + 1)'(1);
        if (addr_r == LAST_ADDR) begin
          // no wrap: the load ends with the last address written
          full_r <= 1'b1;
        end else if (!flushing_r) begin
          addr_r <= addr_r + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.bram_we       = (state_r == S_WR);
  assign bus.bram_addr     = bram_addr_r;
  assign bus.bram_din      = bram_din_r;
  assign bus.words_written = words_written_r;
  assign bus.busy          = (state_r == S_HI) || (state_r == S_LO) || (state_r == S_WR);
  assign bus.done          = (state_r == S_DONE);
  assign bus.full          = full_r;

endmodule

// File: tb/tb_bram_word_loader.sv
// Randomized scoreboard bench for bram_word_loader. Each test builds its byte
// stream, pushes the byte-pair words it should produce into a queue, and a
// monitor pops and compares on every bram_we pulse.
module tb_bram_word_loader;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  wr_t  exp_q[$];
  int   we_cycles[$];
  wr_t  mon_e;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  bram_word_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bram_word_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected word.
  always @(negedge CLK) begin
    if (bus.bram_we === 1'b1) begin
      we_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.bram_addr, bus.bram_din);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.bram_addr), mon_e.addr);
        check("write_data", 32'(bus.bram_din), mon_e.data);
      end
    end
  end

  // Reference model: byte pairs, big-endian, odd tail padded, capped at DEPTH.
  task automatic expect_words(input bq_t b);
    int n;
    n = (b.size() + 1) / 2;
    if (n > DEPTH) n = DEPTH;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = i;
      w.data = {16'h0000, b[2*i], ((2*i + 1) < b.size()) ? b[2*i + 1] : 8'h00};
      exp_q.push_back(w);
    end
  endtask

  task automatic rand_bytes(input int n, output bq_t b);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
  endtask

  task automatic do_start();
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  // Offer bytes; advance only on an observed handshake.
  task automatic send(input bq_t b, input int valid_pct, input bit hold_start);
    int  idx;
    int  guard;
    bit  hs;
    idx = 0;
    guard = 0;
    while (idx < b.size() && guard < b.size() * 20 + 100) begin
      @(negedge CLK);
      bus.in_valid = ($urandom_range(99) < valid_pct);
      bus.in_byte  = bus.in_valid ? b[idx] : 8'($urandom);
      bus.start    = hold_start;
      #1;
      hs = bus.in_valid && bus.in_ready;
      @(posedge CLK);
      if (hs) idx++;
      guard++;
    end
    check("send_complete", 32'(idx), 32'(b.size()));
  endtask

  // Wait for HI or LO, then flush with a competing byte presented.
  task automatic do_flush(input bit from_hi);
    int guard;
    guard = 0;
    do begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      #1;
      guard++;
    end while (bus.in_ready !== 1'b1 && guard < 20);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hEE;
    #1;
    check("ready_low_during_flush", 32'(bus.in_ready), 32'd0);
    @(negedge CLK);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    if (from_hi) check("done_after_hi_flush", 32'(bus.done), 32'd1);
    else         check("we_after_lo_flush", 32'(bus.bram_we), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (bus.done !== 1'b1 && i < limit) begin
      @(negedge CLK);
      i++;
    end
    check("done", 32'(bus.done), 32'd1);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_bram_we"}, 32'(bus.bram_we), 32'd0);
    check({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'd0);
    check({tag, "_bram_din"}, 32'(bus.bram_din), 32'd0);
    check({tag, "_words_written"}, 32'(bus.words_written), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_full"}, 32'(bus.full), 32'd0);
  endtask

  initial begin
    bq_t b;
    int  rej;
    bus.start    = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset_values("reset");

    // Basic load: two words, flush in HI
    we_cycles = {};
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    expect_words(b);
    do_start();
    send(b, 100, 1'b0);
    do_flush(1'b1);
    wait_done(20);
    check("basic_words_written", 32'(bus.words_written), 32'd2);
    check("basic_full", 32'(bus.full), 32'd0);
    check("basic_we_count", 32'(we_cycles.size()), 32'd2);
    if (we_cycles.size() == 2)
      check("basic_we_spacing", 32'(we_cycles[1] - we_cycles[0]), 32'd3);

    // Odd byte count: flush in LO pads with 0x00
    b = '{8'hAB};
    expect_words(b);
    do_start();
    send(b, 100, 1'b0);
    do_flush(1'b0);
    wait_done(20);
    check("odd_words_written", 32'(bus.words_written), 32'd1);

    // Reset in LO after high byte, then restart
    do_start();
    b = '{8'h99};
    send(b, 100, 1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_values("midload_reset");
    b = '{8'h01, 8'h02};
    expect_words(b);
    do_start();
    send(b, 100, 1'b0);
    do_flush(1'b1);
    wait_done(20);
    check("restart_words_written", 32'(bus.words_written), 32'd1);

    // Back-pressure: random gaps in in_valid, odd length
    rand_bytes(41, b);
    expect_words(b);
    do_start();
    send(b, 45, 1'b0);
    do_flush(1'b0);
    wait_done(20);
    check("bp_words_written", 32'(bus.words_written), 32'd21);

    // Fill to capacity
    rand_bytes(2 * DEPTH, b);
    expect_words(b);
    do_start();
    send(b, 100, 1'b0);
    wait_done(20);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_words_written", 32'(bus.words_written), 32'(DEPTH));
    rej = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'h5A;
      #1;
      if (bus.in_ready !== 1'b0) rej++;
    end
    bus.in_valid = 1'b0;
    check("fill_extra_byte_refused", 32'(rej), 32'd0);

    // Reload from DONE with start held during the load
    do_start();
    check("reload_words_written_clear", 32'(bus.words_written), 32'd0);
    check("reload_full_clear", 32'(bus.full), 32'd0);
    rand_bytes(6, b);
    expect_words(b);
    send(b, 70, 1'b1);
    do_flush(1'b1);
    wait_done(20);
    check("reload_words_written", 32'(bus.words_written), 32'd3);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
